aes_key_schedule: RTL and testbench

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

---
 rtl/aes_key_schedule_pkg.sv | 42 ++++
 rtl/aes_key_schedule_subword.sv | 15 +
 rtl/aes_key_schedule.sv | 131 +++++++++++++
 tb/tb_aes_key_schedule.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_schedule_pkg.sv
// Shared definitions for the AES-128 key schedule: round count, Rcon table,
// round-key type, FSM encoding and the forward S-box table.
package aes_key_schedule_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] round_key_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  // Round constants, indexed by the round that consumes them.
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_key_schedule_subword.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word.
module aes_subword
  import aes_key_schedule_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  // Byte-wise substitution, purely combinational.
  always_comb begin
    word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                sbox(word_in[15:8]),  sbox(word_in[7:0])};
  end

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: loads the cipher key, then produces one round key
// per clock into a register file that is read combinationally by index.
module aes_key_schedule
  import aes_key_schedule_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       key_valid_q, key_valid_d;
  round_key_t rk_q [0:NR];
  round_key_t rk_d [0:NR];

  round_key_t prev_key;
  logic [7:0] rcon_sel;
  logic [31:0] sub_word;
  logic [31:0] t_word, w0_n, w1_n, w2_n, w3_n;
  round_key_t next_key;

  // Select the previous round key and its Rcon for the round being built.
  always_comb begin
    prev_key = '0;
    rcon_sel = '0;
    for (int i = 1; i <= NR; i++) begin
      if (round_q == 4'(i)) begin
        prev_key = rk_q[i-1];
        rcon_sel = RCON[i];
      end
    end
  end

  aes_subword u_subword (
    .word_in  ({prev_key[23:0], prev_key[31:24]}),
    .word_out (sub_word)
  );

  // One FIPS-197 key-expansion step: four chained word XORs.
  always_comb begin
    t_word   = sub_word ^ {rcon_sel, 24'h0};
    w0_n     = prev_key[127:96] ^ t_word;
    w1_n     = prev_key[95:64]  ^ w0_n;
    w2_n     = prev_key[63:32]  ^ w1_n;
    w3_n     = prev_key[31:0]   ^ w2_n;
    next_key = {w0_n, w1_n, w2_n, w3_n};
  end

  // Next-state logic: load on start in IDLE, one round key per cycle in EXPAND.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    round_d     = round_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    key_valid_d = key_valid_q;
    rk_d        = rk_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rk_d[0]     = key_in;
          round_d     = 4'd1;
          key_valid_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        for (int i = 1; i <= NR; i++) begin
          if (round_q == 4'(i)) rk_d[i] = next_key;
        end
        round_d = round_q + 4'd1;
        if (round_q == 4'(NR)) begin
          busy_d      = 1'b0;
          done_d      = 1'b1;
          key_valid_d = 1'b1;
          round_d     = 4'd0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      // NOTE: the key file is reset too, so an aborted expansion leaves no key material behind.
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      round_q     <= round_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
      for (int i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
    end
  end

  // Combinational read port; zero when invalid or out of range.
  always_comb begin
    rd_key = '0;
    if (key_valid_q) begin
      for (int i = 0; i <= NR; i++) begin
        if (rd_idx == 4'(i)) rd_key = rk_q[i];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: known-answer table, random keys
// against a word-level key-expansion model, and multi-cycle corner sequences.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         start;
  logic         busy, done, key_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int n_cmp = 0;
  int n_err = 0;

  aes_key_schedule #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rd_idx    (rd_idx),
    .rd_key    (rd_key)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]   m_sbox [256];
  logic [127:0] m_rk [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-oriented FIPS-197 KeyExpansion into m_rk[0..10].
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {m_sbox[temp[31:24]], m_sbox[temp[23:16]], m_sbox[temp[15:8]], m_sbox[temp[7:0]]};
        temp = temp ^ {rc, 24'h0};
        rc   = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge and wait for done; reports edges counted from the start edge.
  task automatic run_expansion(input logic [127:0] key, output int lat);
    key_in = key;
    start  = 1'b1;
    tick();
    lat   = 1;
    start = 1'b0;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    chk("done_seen", 128'(done), 128'd1);
  endtask

  task automatic read_chk(input string name, input int idx, input logic [127:0] exp);
    rd_idx = 4'(idx);
    #1;
    chk(name, rd_key, exp);
  endtask

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_ZERO = 128'h0;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dones, done_edge;
    logic [127:0] last_key, k1, k2, k1_rk10;
    logic have_key;

    vecs[0] = '{key: K_FIPS, idx: 0,  exp: K_FIPS};
    vecs[1] = '{key: K_FIPS, idx: 1,  exp: 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{key: K_FIPS, idx: 10, exp: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[3] = '{key: K_FIPS, idx: 11, exp: 128'h0};
    vecs[4] = '{key: K_FIPS, idx: 15, exp: 128'h0};
    vecs[5] = '{key: K_ZERO, idx: 1,  exp: 128'h62636363626363636263636362636363};
    vecs[6] = '{key: K_ZERO, idx: 10, exp: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[7] = '{key: K_SEQ,  idx: 10, exp: 128'h13111d7fe3944a17f307a78b4d2b30c5};

    build_sbox();

    rst = 1'b1; start = 1'b0; key_in = '0; rd_idx = 4'd0;
    tick(); tick();
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_key_valid", 128'(key_valid), 128'd0);
    rst = 1'b0;
    tick();
    read_chk("rd_before_start_idx5", 5, 128'h0);

    // Known-answer table.
    have_key = 1'b0;
    last_key = '0;
    foreach (vecs[v]) begin
      if (!have_key || vecs[v].key !== last_key) begin
        run_expansion(vecs[v].key, lat);
        chk("latency", 128'(lat), 128'd11);
        chk("key_valid_after_done", 128'(key_valid), 128'd1);
        tick();
        chk("done_one_cycle", 128'(done), 128'd0);
        last_key = vecs[v].key;
        have_key = 1'b1;
      end
      read_chk($sformatf("kat_%0d_idx%0d", v, vecs[v].idx), vecs[v].idx, vecs[v].exp);
    end

    // Random keys against the model, every index.
    repeat (5) begin
      k1 = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k1);
      run_expansion(k1, lat);
      chk("rand_latency", 128'(lat), 128'd11);
      for (int i = 0; i <= 10; i++) read_chk($sformatf("rand_idx%0d", i), i, m_rk[i]);
    end

    // Back-to-back: restart on the cycle right after done.
    model_expand(K_SEQ);
    run_expansion(K_FIPS, lat);
    key_in = K_SEQ;
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_key_valid_drop", 128'(key_valid), 128'd0);
    chk("b2b_busy", 128'(busy), 128'd1);
    read_chk("b2b_rd_while_busy", 10, 128'h0);
    lat = 1;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    chk("b2b_latency", 128'(lat), 128'd11);
    read_chk("b2b_rk10", 10, m_rk[10]);

    // start held for 20 edges, key_in changed after edge 3.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k1;
    model_expand(k1);
    k1_rk10 = m_rk[10];
    model_expand(k2);
    tick();
    rd_idx = 4'd10;
    key_in = k1;
    start  = 1'b1;
    dones  = 0;
    done_edge = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (done) begin
        dones++;
        done_edge = e;
        chk("hold_first_rk10", rd_key, k1_rk10);
      end
      if (e == 3) key_in = k2;
      if (e == 12) chk("hold_restart_busy", 128'(busy), 128'd1);
    end
    start = 1'b0;
    chk("hold_done_count", 128'(dones), 128'd1);
    chk("hold_done_edge", 128'(done_edge), 128'd11);
    lat = 20;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk("hold_second_done_edge", 128'(lat), 128'd22);
    read_chk("hold_second_rk10", 10, m_rk[10]);

    // Reset 5 edges into an expansion.
    key_in = {$urandom, $urandom, $urandom, $urandom};
    model_expand(key_in);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_key_valid", 128'(key_valid), 128'd0);
    for (int i = 0; i <= 15; i++) read_chk($sformatf("abort_rd_idx%0d", i), i, 128'h0);
    tick();
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      tick();
      if (done) dones++;
    end
    chk("abort_no_done", 128'(dones), 128'd0);
    chk("abort_idle_busy", 128'(busy), 128'd0);

    // First edge after reset release honours start.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_after_reset_busy", 128'(busy), 128'd1);
    lat = 1;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    chk("start_after_reset_latency", 128'(lat), 128'd11);
    read_chk("start_after_reset_rk10", 10, m_rk[10]);
    read_chk("start_after_reset_rk0", 0, m_rk[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
